// File: rtl/ebus_diag_responder.sv
// EBUS-side target for DTE diagnostic transactions: decodes ds on strobe rise, writes/reads local registers.
// Optional EBUS_PARITY_EN adds odd parity on EBUS data (dataParIn, dataParOut, sticky parErr).
module ebus_diag_responder #(
    parameter logic [2:0]  UNIT_SEL = 3'o0,
    parameter int unsigned N_REGS   = 4,
    parameter int unsigned SETTLE   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [0:6]            ds,
    input  logic                  diagStrobe,
    input  logic [0:35]           dataIn,
    output logic                  driving,
    output logic [0:35]           dataOut,
    output logic                  cmdPulse,
    output logic [35:0]           cmdWord,
    output logic [N_REGS*36-1:0]  regOut,
    output logic                  errSticky
`ifdef EBUS_PARITY_EN
    ,
    input  logic                  dataParIn,
    output logic                  dataParOut,
    output logic                  parErr
`endif
);

    typedef enum logic [1:0] {IDLE, WSETTLE, READ} state_t;

    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);

    state_t       state, stateNext;
    logic         strobeQ;
    logic [2:0]   dsSubQ;
    logic [2:0]   cnt, cntNext;
    logic [35:0]  regs [N_REGS];
    logic [17:0]  xactCount;

    logic         rise, selected;
    logic         latchDs, writeEn, abortEn, xactInc, drivingNext;
    logic [0:35]  dataOutNext, rdWord, statusWord;
    logic [2:0]   rdSub;
    logic         parBit, badPar;

`ifdef EBUS_PARITY_EN
    assign parBit     = parErr;
    assign badPar     = ~^{dataIn, dataParIn};
    assign dataParOut = driving & ~^dataOut;
`else
    assign parBit     = 1'b0;
    assign badPar     = 1'b0;
`endif

    assign rise       = diagStrobe & ~strobeQ;
    assign selected   = (ds[1:3] == UNIT_SEL);
    assign statusWord = {xactCount, 16'b0, errSticky, parBit};
    // In IDLE the read word is taken straight from ds so data is valid the cycle after the rise.
    assign rdSub      = (state == IDLE) ? ds[4:6] : dsSubQ;

    always_comb begin
        rdWord = '0;
        for (int unsigned i = 0; i < N_REGS; i++)
            if (rdSub == 3'(i)) rdWord = regs[i];
        if (rdSub == 3'd6) rdWord = statusWord;
    end

    always_comb begin
        regOut = '0;
        for (int unsigned i = 0; i < N_REGS; i++)
            regOut[i*36 +: 36] = regs[i];
    end

    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        latchDs     = 1'b0;
        writeEn     = 1'b0;
        abortEn     = 1'b0;
        xactInc     = 1'b0;
        drivingNext = 1'b0;
        dataOutNext = '0;
        case (state)
            IDLE: begin
                if (rise && selected) begin
                    latchDs = 1'b1;
                    if (ds[0]) begin
                        stateNext   = READ;
                        drivingNext = 1'b1;
                        dataOutNext = rdWord;
                    end else begin
                        stateNext = WSETTLE;
                        cntNext   = '0;
                    end
                end
            end
            WSETTLE: begin
                if (!diagStrobe) begin
                    abortEn   = 1'b1;
                    xactInc   = 1'b1;
                    stateNext = IDLE;
                end else if (cnt == SETTLE_LAST) begin
                    writeEn   = 1'b1;
                    xactInc   = 1'b1;
                    stateNext = IDLE;
                end else begin
                    cntNext = cnt + 3'd1;
                end
            end
            READ: begin
                if (diagStrobe) begin
                    drivingNext = 1'b1;
                    dataOutNext = rdWord;
                end else begin
                    xactInc   = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            strobeQ   <= 1'b0;
            dsSubQ    <= '0;
            cnt       <= '0;
            xactCount <= '0;
            driving   <= 1'b0;
            dataOut   <= '0;
            cmdPulse  <= 1'b0;
            cmdWord   <= '0;
            errSticky <= 1'b0;
            for (int unsigned i = 0; i < N_REGS; i++) regs[i] <= '0;
`ifdef EBUS_PARITY_EN
            parErr    <= 1'b0;
`endif
        end else begin
            state    <= stateNext;
            strobeQ  <= diagStrobe;
            cnt      <= cntNext;
            driving  <= drivingNext;
            dataOut  <= dataOutNext;
            cmdPulse <= 1'b0;
            if (latchDs) dsSubQ <= ds[4:6];
            if (xactInc) xactCount <= xactCount + 18'd1;
            if (abortEn) errSticky <= 1'b1;
            if (writeEn) begin
                for (int unsigned i = 0; i < N_REGS; i++)
                    if (dsSubQ == 3'(i)) regs[i] <= dataIn;
                if (dsSubQ == 3'd6) errSticky <= 1'b0;
                if (dsSubQ == 3'd7) begin
                    cmdWord  <= dataIn;
                    cmdPulse <= 1'b1;
                end
`ifdef EBUS_PARITY_EN
                // A bad-parity write to sub-code 6 still leaves parErr set.
                if (badPar) parErr <= 1'b1;
                else if (dsSubQ == 3'd6) parErr <= 1'b0;
`endif
            end
        end
    end

    logic unusedBadPar;
    assign unusedBadPar = badPar;

endmodule

// File: tb/tb_ebus_diag_responder.sv
// Randomized self-checking bench for ebus_diag_responder against a transaction-level model.
module tb_ebus_diag_responder;

    localparam logic [2:0]  UNIT_SEL = 3'o0;
    localparam int unsigned N_REGS   = 4;
    localparam int unsigned SETTLE   = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [0:6]           ds = '0;
    logic                 diagStrobe = 1'b0;
    logic [0:35]          dataIn = '0;
    logic                 driving;
    logic [0:35]          dataOut;
    logic                 cmdPulse;
    logic [35:0]          cmdWord;
    logic [N_REGS*36-1:0] regOut;
    logic                 errSticky;

    ebus_diag_responder #(.UNIT_SEL(UNIT_SEL), .N_REGS(N_REGS), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .ds(ds), .diagStrobe(diagStrobe), .dataIn(dataIn),
        .driving(driving), .dataOut(dataOut), .cmdPulse(cmdPulse), .cmdWord(cmdWord),
        .regOut(regOut), .errSticky(errSticky)
    );

    always #5 clk = ~clk;

    // Transaction-level model of the unit's visible state.
    logic [35:0] mRegs [8];
    logic [17:0] mCount;
    logic        mErr;
    logic [35:0] mCmd;

    int total = 0;
    int bad   = 0;

    task automatic checkVal(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] expRead(input logic [2:0] sub);
        if (32'(sub) < N_REGS) return mRegs[sub];
        if (sub == 3'd6) return {mCount, 16'b0, mErr, 1'b0};
        return '0;
    endfunction

    function automatic logic [N_REGS*36-1:0] packRegs();
        logic [N_REGS*36-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < N_REGS; i++) p[i*36 +: 36] = mRegs[i];
        return p;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mRegs[i] = '0;
        mCount = '0;
        mErr   = 1'b0;
        mCmd   = '0;
    endtask

    // Strobe is sampled high on edges 0..hold-1; edge 0 is the rise.
    task automatic runXact(input logic [6:0] d, input logic [35:0] w, input int unsigned hold);
        logic        sel, rd, ok, expDrv;
        logic [2:0]  sub;
        logic [35:0] expWord;
        sel     = (d[5:3] == UNIT_SEL);
        rd      = d[6];
        sub     = d[2:0];
        ok      = hold > SETTLE;
        expWord = expRead(sub);
        ds = d;
        dataIn = w;
        diagStrobe = 1'b1;
        for (int unsigned k = 0; k < hold + 3; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) ds = 7'($urandom);
            if (k == hold - 1) diagStrobe = 1'b0;
            @(negedge clk);
            expDrv = sel && rd && (k < hold);
            checkVal("driving", driving, expDrv);
            checkVal("dataOut", dataOut, expDrv ? expWord : 36'd0);
            checkVal("cmdPulse", cmdPulse, sel && !rd && sub == 3'd7 && ok && k == SETTLE);
        end
        if (sel) begin
            mCount = mCount + 18'd1;
            if (!rd) begin
                if (!ok) mErr = 1'b1;
                else begin
                    if (32'(sub) < N_REGS) mRegs[sub] = w;
                    if (sub == 3'd6) mErr = 1'b0;
                    if (sub == 3'd7) mCmd = w;
                end
            end
        end
        checkVal("regOut", regOut, packRegs());
        checkVal("errSticky", errSticky, mErr);
        checkVal("cmdWord", cmdWord, mCmd);
    endtask

    initial begin
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("rst_driving", driving, 1'b0);
        checkVal("rst_dataOut", dataOut, 36'd0);
        checkVal("rst_regOut", regOut, 144'd0);
        checkVal("rst_err", errSticky, 1'b0);
        checkVal("rst_cmd", {cmdPulse, cmdWord}, 37'd0);
        rst_n = 1'b1;

        runXact(7'o011, 36'o555555_555555, 4);
        runXact(7'o111, 36'd0, 3);
        runXact(7'o106, 36'd0, 2);
        runXact(7'o001, 36'o123456_701234, 4);
        runXact(7'o101, 36'd0, 3);
        runXact(7'o106, 36'd0, 2);
        runXact(7'o007, 36'o777777_000001, 4);
        runXact(7'o000, 36'o111111_111111, 1);
        runXact(7'o106, 36'd0, 2);
        runXact(7'o006, 36'd0, 4);
        runXact(7'o106, 36'd0, 1);

        for (int n = 0; n < 150; n++) begin
            logic [6:0]  d;
            logic [35:0] w;
            d = 7'($urandom);
            if ($urandom_range(3, 0) != 0) d[5:3] = UNIT_SEL;
            w = {4'($urandom), 32'($urandom)};
            runXact(d, w, $urandom_range(6, 1));
        end

        @(negedge clk);
        force dut.xactCount = 18'o777776;
        @(negedge clk);
        release dut.xactCount;
        mCount = 18'o777776;
        runXact(7'o002, {4'($urandom), 32'($urandom)}, 5);
        runXact(7'o106, 36'd0, 2);
        runXact(7'o106, 36'd0, 2);

        runXact(7'o003, 36'o707070_070707, 4);
        ds = 7'o100;
        diagStrobe = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        modelReset();
        checkVal("rstrd_driving", driving, 1'b0);
        checkVal("rstrd_dataOut", dataOut, 36'd0);
        checkVal("rstrd_regOut", regOut, packRegs());
        checkVal("rstrd_err", errSticky, mErr);
        rst_n = 1'b1;
        diagStrobe = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkVal("rstrd_nodrive", driving, 1'b0);
        end
        runXact(7'o106, 36'd0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
